// File: rtl/port_ingress_queue_pkg.sv
// Shared types and helpers for the per-port ingress queue.
package port_ingress_queue_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned DATA_W    = 8;

  typedef struct packed {
    logic [NUM_PORTS-1:0] target;
    logic [NUM_PORTS-1:0] source;
    logic [DATA_W-1:0]    data;
  } packet_t;

  // True when exactly one bit of a 4-bit port vector is set.
  function automatic logic is_onehot4(input logic [NUM_PORTS-1:0] v);
    return (v != '0) && ((v & (v - NUM_PORTS'(1))) == '0);
  endfunction

endpackage

// File: rtl/port_ingress_queue_if.sv
// Upstream valid/ready packet bus plus the switch-port facing output bus.
interface port_ingress_queue_if;
  import port_ingress_queue_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_PORTS-1:0] in_source;
  logic [NUM_PORTS-1:0] in_target;
  logic [DATA_W-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_PORTS-1:0] out_source;
  logic [NUM_PORTS-1:0] out_target;
  logic [DATA_W-1:0]    out_data;

  // master: traffic source and switch port; slave: the ingress queue
  modport master (
    output in_valid, in_source, in_target, in_data, out_ready,
    input  in_ready, out_valid, out_source, out_target, out_data
  );

  modport slave (
    input  in_valid, in_source, in_target, in_data, out_ready,
    output in_ready, out_valid, out_source, out_target, out_data
  );

endinterface

// File: rtl/port_ingress_queue_sync_fifo.sv
// Show-ahead synchronous FIFO; when empty the output holds the last popped entry.
module sync_fifo
  import port_ingress_queue_pkg::*;
#(
  parameter type         T     = packet_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  T                       wdata,
  output T                       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] last_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign level    = level_q;
  // The slot behind the read pointer is never overwritten while empty.
  assign last_ptr = rd_ptr_q - PTR_W'(1);
  assign rdata    = empty ? mem_q[last_ptr] : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/port_ingress_queue.sv
// Per-port ingress stage: filters malformed packets, buffers good ones for one switch port.
module port_ingress_queue
  import port_ingress_queue_pkg::*;
#(
  parameter int unsigned PORT_ID    = 0,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  port_ingress_queue_if.slave     bus,
  output logic [$clog2(DEPTH):0]  level,
  output logic [DROP_CNT_W-1:0]   drop_count,
  output logic                    drop_pulse
);

  localparam logic [NUM_PORTS-1:0] LEGAL_SRC = NUM_PORTS'(1 << PORT_ID);

  packet_t                 in_pkt;
  packet_t                 head_pkt;
  logic                    accept;
  logic                    pkt_good;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DROP_CNT_W-1:0]   drop_count_q, drop_count_d;
  logic                    drop_pulse_q, drop_pulse_d;

  assign in_pkt = '{target: bus.in_target, source: bus.in_source, data: bus.in_data};

  // Rejects wrong source, non-one-hot target, or a packet addressed back to its source.
  assign pkt_good = (bus.in_source == LEGAL_SRC)
                  & is_onehot4(bus.in_target)
                  & (bus.in_target != bus.in_source);

  assign bus.in_ready = ~fifo_full;
  assign accept       = bus.in_valid & ~fifo_full;
  assign push         = accept & pkt_good;
  assign pop          = ~fifo_empty & bus.out_ready;

  sync_fifo #(
    .T     (packet_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (in_pkt),
    .rdata (head_pkt),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid  = ~fifo_empty;
  assign bus.out_source = head_pkt.source;
  assign bus.out_target = head_pkt.target;
  assign bus.out_data   = head_pkt.data;

  always_comb begin
    drop_count_d = drop_count_q;
    drop_pulse_d = 1'b0;
    if (accept && !pkt_good) begin
      drop_pulse_d = 1'b1;
      if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + DROP_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_q <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      drop_count_q <= drop_count_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  assign drop_count = drop_count_q;
  assign drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_port_ingress_queue.sv
// Self-checking bench for port_ingress_queue (PORT_ID = 1, DEPTH = 4) against a queue-based model.
module tb_port_ingress_queue;
  import port_ingress_queue_pkg::*;

  localparam int unsigned PORT_ID    = 1;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned DROP_CNT_W = 8;
  localparam int          DROP_MAX   = 255;

  logic       clk;
  logic       rst_n;
  logic [2:0] level;
  logic [7:0] drop_count;
  logic       drop_pulse;

  port_ingress_queue_if ifc ();

  port_ingress_queue #(
    .PORT_ID    (PORT_ID),
    .DEPTH      (DEPTH),
    .DROP_CNT_W (DROP_CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifc),
    .level      (level),
    .drop_count (drop_count),
    .drop_pulse (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      n_cmp;
  int      n_fail;
  packet_t ref_q[$];
  packet_t last_out;
  int      exp_drop;
  bit      exp_pulse;

  function automatic bit good_pkt(input packet_t p);
    logic [3:0] legal;
    legal = 4'b0001 << PORT_ID;
    return (p.source == legal) && ($countones(p.target) == 1) && (p.target != p.source);
  endfunction

  function automatic packet_t exp_head();
    return (ref_q.size() > 0) ? ref_q[0] : last_out;
  endfunction

  task automatic model_reset();
    ref_q.delete();
    last_out  = '0;
    exp_drop  = 0;
    exp_pulse = 1'b0;
  endtask

  task automatic drive(input bit v, input packet_t p);
    ifc.in_valid  = v;
    ifc.in_source = p.source;
    ifc.in_target = p.target;
    ifc.in_data   = p.data;
  endtask

  // One clock: predict the handshakes from current inputs, advance the model, settle past the edge.
  task automatic tick(output bit acc);
    packet_t p;
    bit      pop;
    p   = '{target: ifc.in_target, source: ifc.in_source, data: ifc.in_data};
    acc = ifc.in_valid && (ref_q.size() < DEPTH);
    pop = (ref_q.size() > 0) && ifc.out_ready;
    @(posedge clk);
    if (pop) last_out = ref_q.pop_front();
    exp_pulse = acc && !good_pkt(p);
    if (acc && good_pkt(p)) ref_q.push_back(p);
    if (exp_pulse && exp_drop < DROP_MAX) exp_drop++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0);
    ifc.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready); end
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
    n_cmp++; if ({ifc.out_target, ifc.out_source, ifc.out_data} !== 16'h0) begin
      n_fail++; $display("FAIL reset_out_bus: got %h want 0000", {ifc.out_target, ifc.out_source, ifc.out_data}); end
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (drop_count !== 8'd0 || drop_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_drop: got cnt %0d pulse %b want 0 0", drop_count, drop_pulse); end
  endtask

  task automatic test_single();
    bit acc;
    ifc.out_ready = 1'b1;
    drive(1'b1, '{target: 4'b0100, source: 4'b0010, data: 8'hAA});
    tick(acc);
    drive(1'b0, '0);
    n_cmp++; if (ifc.out_valid !== 1'b1 || ifc.out_data !== 8'hAA) begin
      n_fail++; $display("FAIL single_out: got v=%b d=%h want v=1 d=aa", ifc.out_valid, ifc.out_data); end
    n_cmp++; if (level !== 3'd1) begin n_fail++; $display("FAIL single_level1: got %0d want 1", level); end
    tick(acc);
    n_cmp++; if (level !== 3'd0 || ifc.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got lvl=%0d v=%b want 0 0", level, ifc.out_valid); end
    n_cmp++; if (ifc.out_data !== 8'hAA || drop_count !== 8'd0) begin
      n_fail++; $display("FAIL single_hold: got d=%h cnt=%0d want aa 0", ifc.out_data, drop_count); end
  endtask

  task automatic test_fill();
    bit   acc;
    logic [7:0] got[$];
    ifc.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, '{target: 4'b1000, source: 4'b0010, data: 8'(i)});
      tick(acc);
    end
    drive(1'b1, '{target: 4'b1000, source: 4'b0010, data: 8'h05});
    n_cmp++; if (ifc.in_ready !== 1'b0 || level !== 3'd4) begin
      n_fail++; $display("FAIL fill_full: got rdy=%b lvl=%0d want 0 4", ifc.in_ready, level); end
    repeat (2) tick(acc);
    n_cmp++; if (level !== 3'd4 || ifc.out_data !== 8'h01) begin
      n_fail++; $display("FAIL fill_hold: got lvl=%0d d=%h want 4 01", level, ifc.out_data); end
    ifc.out_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      if (ifc.out_valid) got.push_back(ifc.out_data);
      tick(acc);
      if (acc) ifc.in_valid = 1'b0;
    end
    n_cmp++; if (got.size() != 5) begin n_fail++; $display("FAIL fill_count: got %0d want 5", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++; if (got[i] !== 8'(i + 1)) begin
        n_fail++; $display("FAIL fill_order[%0d]: got %h want %h", i, got[i], 8'(i + 1)); end
    end
    drive(1'b0, '0);
    tick(acc);
  endtask

  task automatic test_drop();
    bit      acc;
    packet_t bad[3];
    bad[0] = '{target: 4'b0100, source: 4'b0001, data: 8'h11};
    bad[1] = '{target: 4'b0110, source: 4'b0010, data: 8'h22};
    bad[2] = '{target: 4'b0010, source: 4'b0010, data: 8'h33};
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bad[i]);
      n_cmp++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready[%0d]: got %b want 1", i, ifc.in_ready); end
      tick(acc);
      n_cmp++; if (drop_pulse !== 1'b1 || ifc.out_valid !== 1'b0 || level !== 3'd0) begin
        n_fail++; $display("FAIL drop_pkt[%0d]: got pulse=%b v=%b lvl=%0d want 1 0 0", i, drop_pulse, ifc.out_valid, level); end
    end
    drive(1'b0, '0);
    tick(acc);
    n_cmp++; if (drop_count !== 8'd3 || drop_pulse !== 1'b0) begin
      n_fail++; $display("FAIL drop_total: got cnt=%0d pulse=%b want 3 0", drop_count, drop_pulse); end
  endtask

  task automatic test_back_to_back();
    bit      acc;
    packet_t p;
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, '{target: 4'b0001, source: 4'b0010, data: 8'(8'h40 + i)});
      tick(acc);
    end
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      p = '{target: 4'b0001 << (2 * (i % 2)), source: 4'b0010, data: 8'($urandom)};
      drive(1'b1, p);
      p = exp_head();
      n_cmp++; if (level !== 3'd2 || ifc.out_data !== p.data || ifc.out_target !== p.target) begin
        n_fail++; $display("FAIL b2b[%0d]: got lvl=%0d d=%h t=%b want 2 %h %b", i, level, ifc.out_data, ifc.out_target, p.data, p.target); end
      tick(acc);
    end
    drive(1'b0, '0);
    n_cmp++; if (level !== 3'd2) begin n_fail++; $display("FAIL b2b_final_level: got %0d want 2", level); end
    repeat (3) tick(acc);
  endtask

  task automatic test_random();
    bit      acc;
    bit      stalled;
    packet_t p;
    packet_t h;
    stalled = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!stalled) begin
        p.data = 8'($urandom);
        if ($urandom_range(0, 9) < 7) begin
          p.source = 4'b0010;
          p.target = 4'b0001 << $urandom_range(0, 3);
        end else begin
          p.source = 4'($urandom);
          p.target = 4'($urandom);
        end
        drive(($urandom_range(0, 3) != 0), p);
      end
      ifc.out_ready = ($urandom_range(0, 2) != 0);
      h = exp_head();
      n_cmp++; if (level !== 3'(ref_q.size()) || ifc.in_ready !== (ref_q.size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_level[%0d]: got lvl=%0d rdy=%b want %0d", i, level, ifc.in_ready, ref_q.size()); end
      n_cmp++; if (ifc.out_valid !== (ref_q.size() > 0) || {ifc.out_target, ifc.out_source, ifc.out_data} !== h) begin
        n_fail++; $display("FAIL rand_out[%0d]: got v=%b pkt=%h want pkt=%h", i, ifc.out_valid,
                           {ifc.out_target, ifc.out_source, ifc.out_data}, h); end
      n_cmp++; if (drop_count !== 8'(exp_drop) || drop_pulse !== exp_pulse) begin
        n_fail++; $display("FAIL rand_drop[%0d]: got cnt=%0d pulse=%b want %0d %b", i, drop_count, drop_pulse, exp_drop, exp_pulse); end
      stalled = ifc.in_valid && (ref_q.size() >= DEPTH);
      tick(acc);
    end
    drive(1'b0, '0);
    ifc.out_ready = 1'b1;
    repeat (5) tick(acc);
  endtask

  task automatic test_saturate();
    bit acc;
    ifc.out_ready = 1'b1;
    drive(1'b1, '{target: 4'b0100, source: 4'b0001, data: 8'h5A});
    repeat (300) tick(acc);
    n_cmp++; if (drop_count !== 8'(exp_drop) || exp_drop != DROP_MAX) begin
      n_fail++; $display("FAIL sat_count: got %0d want %0d", drop_count, DROP_MAX); end
    n_cmp++; if (drop_pulse !== 1'b1) begin n_fail++; $display("FAIL sat_pulse: got %b want 1", drop_pulse); end
    drive(1'b0, '0);
    tick(acc);
  endtask

  task automatic test_reset_mid();
    bit acc;
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, '{target: 4'b0100, source: 4'b0010, data: 8'(8'hC0 + i)});
      tick(acc);
    end
    drive(1'b1, '{target: 4'b0100, source: 4'b0010, data: 8'hC3});
    n_cmp++; if (level !== 3'd3 || drop_count === 8'd0) begin
      n_fail++; $display("FAIL mid_pre: got lvl=%0d cnt=%0d want 3 nonzero", level, drop_count); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ifc.out_valid !== 1'b0 || level !== 3'd0 || drop_count !== 8'd0 || ifc.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_async: got v=%b lvl=%0d cnt=%0d rdy=%b want 0 0 0 1", ifc.out_valid, level, drop_count, ifc.in_ready); end
    n_cmp++; if (ifc.out_data !== 8'h00 || drop_pulse !== 1'b0) begin
      n_fail++; $display("FAIL mid_bus: got d=%h pulse=%b want 00 0", ifc.out_data, drop_pulse); end
    drive(1'b0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick(acc);
    n_cmp++; if (ifc.out_valid !== 1'b0 || level !== 3'd0) begin
      n_fail++; $display("FAIL mid_after: got v=%b lvl=%0d want 0 0", ifc.out_valid, level); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    model_reset();
    test_reset();
    test_single();
    test_fill();
    test_drop();
    test_back_to_back();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
